// File: rtl/interrupt_ack_sequencer.sv
// Priority resolver and two-pulse 8086 INTA sequencer with in-service register and EOI handling.
// Define ROTATE_PRIORITY_EN to make EOI/AEOI clears rotate the priority order.
module interrupt_ack_sequencer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] risedBits,
  input  logic       INTA_n,
  input  logic [7:0] ICW2,
  input  logic       AEOI,
  input  logic       eoiPulse,
  input  logic       eoiSpecific,
  input  logic [2:0] eoiLevel,
  input  logic       readPriorityAck,
  output logic       INT,
  output logic [2:0] resetIRR,
  output logic       readPriority,
  output logic [7:0] dataBuffer,
  output logic       dataBufferEn,
  output logic [7:0] ISR,
  output logic       ackError
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, CLR, WAIT1, WAIT2, VEC} state_t;

  state_t        state_q, state_d;
  logic          inta_s1_q, inta_s2_q, inta_s3_q;
  logic          inta_fall, inta_rise;
  logic          int_q, int_d;
  logic [2:0]    reset_irr_q, reset_irr_d;
  logic          read_prio_q, read_prio_d;
  logic [7:0]    data_buf_q, data_buf_d;
  logic          data_en_q, data_en_d;
  logic [7:0]    isr_q, isr_d;
  logic          ack_error_q, ack_error_d;
  logic [2:0]    id_q, id_d;
  logic          spurious_q, spurious_d;
  logic          ack_cap_q, ack_cap_d;
  logic          rise_seen_q, rise_seen_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    isr_set, isr_clr;
  logic [2:0]    base;
  logic          sel_valid, blocked;
  logic [2:0]    sel_id, idx;
  logic          eoi_valid;
  logic [2:0]    eoi_bit;
  logic          rot_hit;
  logic [2:0]    rot_bit;
  logic          unused_icw2;

  assign unused_icw2 = ^ICW2[2:0];
  assign inta_fall   = inta_s3_q & ~inta_s2_q;
  assign inta_rise   = ~inta_s3_q & inta_s2_q;

`ifdef ROTATE_PRIORITY_EN
  logic [2:0] lowest_q, lowest_d;

  always_comb begin
    lowest_d = lowest_q;
    if (rot_hit) lowest_d = rot_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lowest_q <= 3'd7;
    else        lowest_q <= lowest_d;
  end

  assign base = lowest_q;
`else
  logic unused_rot;
  assign base       = 3'd7;
  assign unused_rot = rot_hit ^ (^rot_bit);
`endif

  // Walk from highest to lowest priority; an in-service level masks itself and everything below it.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = 3'd7;
    blocked   = 1'b0;
    idx       = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = base + 3'(k);
      if (!blocked && !sel_valid) begin
        if (isr_q[idx]) begin
          blocked = 1'b1;
        end else if (risedBits[idx]) begin
          sel_valid = 1'b1;
          sel_id    = idx;
        end
      end
    end
  end

  always_comb begin
    eoi_valid = 1'b0;
    eoi_bit   = 3'd0;
    if (eoiSpecific) begin
      eoi_bit   = eoiLevel;
      eoi_valid = isr_q[eoiLevel];
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (isr_q[i]) begin
          eoi_valid = 1'b1;
          eoi_bit   = 3'(i);
        end
      end
    end
  end

  // IRR clear handshake: readPriority is a level held with resetIRR stable until readPriorityAck
  // differs from the copy captured when the request was raised (one toggle per request).
  always_comb begin
    state_d     = state_q;
    int_d       = int_q;
    reset_irr_d = reset_irr_q;
    read_prio_d = read_prio_q;
    data_buf_d  = data_buf_q;
    data_en_d   = data_en_q;
    ack_error_d = ack_error_q;
    id_d        = id_q;
    spurious_d  = spurious_q;
    ack_cap_d   = ack_cap_q;
    rise_seen_d = rise_seen_q;
    timer_d     = timer_q;
    isr_set     = 8'h00;
    isr_clr     = 8'h00;
    rot_hit     = 1'b0;
    rot_bit     = 3'd0;
    if (eoiPulse && eoi_valid) begin
      isr_clr[eoi_bit] = 1'b1;
      rot_hit          = 1'b1;
      rot_bit          = eoi_bit;
    end
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          int_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (inta_fall) begin
          int_d       = 1'b0;
          rise_seen_d = 1'b0;
          timer_d     = '0;
          if (sel_valid) begin
            id_d            = sel_id;
            spurious_d      = 1'b0;
            isr_set[sel_id] = 1'b1;
            reset_irr_d     = sel_id;
            read_prio_d     = 1'b1;
            ack_cap_d       = readPriorityAck;
            state_d         = CLR;
          end else begin
            id_d       = 3'd7;
            spurious_d = 1'b1;
            state_d    = WAIT1;
          end
        end
      end
      CLR: begin
        if (inta_rise) rise_seen_d = 1'b1;
        if (readPriorityAck != ack_cap_q) begin
          read_prio_d = 1'b0;
          state_d     = WAIT1;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          ack_error_d = 1'b1;
          read_prio_d = 1'b0;
          state_d     = WAIT1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT1: begin
        if (inta_rise || rise_seen_q) begin
          rise_seen_d = 1'b0;
          state_d     = WAIT2;
        end
      end
      WAIT2: begin
        if (inta_fall) begin
          data_buf_d = {ICW2[7:3], id_q};
          data_en_d  = 1'b1;
          state_d    = VEC;
        end
      end
      VEC: begin
        if (inta_rise) begin
          data_en_d = 1'b0;
          state_d   = IDLE;
          if (AEOI && !spurious_q) begin
            isr_clr[id_q] = 1'b1;
            rot_hit       = 1'b1;
            rot_bit       = id_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Set after clear so a same-cycle EOI cannot undo a fresh in-service mark.
    isr_d = (isr_q & ~isr_clr) | isr_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      inta_s1_q   <= 1'b1;
      inta_s2_q   <= 1'b1;
      inta_s3_q   <= 1'b1;
      int_q       <= 1'b0;
      reset_irr_q <= 3'd0;
      read_prio_q <= 1'b0;
      data_buf_q  <= 8'h00;
      data_en_q   <= 1'b0;
      isr_q       <= 8'h00;
      ack_error_q <= 1'b0;
      id_q        <= 3'd0;
      spurious_q  <= 1'b0;
      ack_cap_q   <= 1'b0;
      rise_seen_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      inta_s1_q   <= INTA_n;
      inta_s2_q   <= inta_s1_q;
      inta_s3_q   <= inta_s2_q;
      int_q       <= int_d;
      reset_irr_q <= reset_irr_d;
      read_prio_q <= read_prio_d;
      data_buf_q  <= data_buf_d;
      data_en_q   <= data_en_d;
      isr_q       <= isr_d;
      ack_error_q <= ack_error_d;
      id_q        <= id_d;
      spurious_q  <= spurious_d;
      ack_cap_q   <= ack_cap_d;
      rise_seen_q <= rise_seen_d;
      timer_q     <= timer_d;
    end
  end

  assign INT          = int_q;
  assign resetIRR     = reset_irr_q;
  assign readPriority = read_prio_q;
  assign dataBuffer   = data_buf_q;
  assign dataBufferEn = data_en_q;
  assign ISR          = isr_q;
  assign ackError     = ack_error_q;
endmodule
